// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file and an auto-incrementing pointer.
// Bus writes land in the register file and are echoed on a one-cycle strobe.
// The local side can preload registers at any time. A read byte is snapshotted
// when its transfer starts, so later local writes do not disturb it.
module i2c_target_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h1D,
   parameter int         NUM_REGS = 64,
   parameter int         PTR_W    = 6,
   parameter int         FILT     = 3
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   input  logic             loc_we,
   input  logic [PTR_W-1:0] loc_addr,
   input  logic [7:0]       loc_wdata,
   output logic             bus_wr_stb,
   output logic [PTR_W-1:0] bus_wr_addr,
   output logic [7:0]       bus_wr_data,
   output logic             busy
);

   localparam int              CNT_W   = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
      ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK, ST_IGNORE
   } state_t;

   // Line conditioning: bit 0 is SCL, bit 1 is SDA
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_filt;
   logic [1:0]       r_filt_d;
   logic [CNT_W-1:0] r_scl_cnt;
   logic [CNT_W-1:0] r_sda_cnt;

   // Protocol state
   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [7:0]       r_shift;
   logic             r_sda_oe;
   logic             r_busy;
   logic [PTR_W-1:0] r_ptr;
   logic             r_rw;
   logic             r_ack_seen;
   logic [7:0]       r_regs [NUM_REGS];

   // Registered write strobe
   logic             r_stb;
   logic [PTR_W-1:0] r_stb_addr;
   logic [7:0]       r_stb_data;

   // Next-state values from the FSM decode
   state_t           w_nxt_state;
   logic [3:0]       w_nxt_cnt;
   logic [7:0]       w_nxt_shift;
   logic             w_nxt_oe;
   logic             w_nxt_busy;
   logic [PTR_W-1:0] w_nxt_ptr;
   logic             w_nxt_rw;
   logic             w_nxt_ack;
   logic             w_bus_we;
   logic [7:0]       w_rx_byte;

   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;
   logic w_sda;

   // Synchronize both pads, accept a new level only after FILT identical samples
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync1   <= 2'b11;
         r_sync2   <= 2'b11;
         r_filt    <= 2'b11;
         r_filt_d  <= 2'b11;
         r_scl_cnt <= '0;
         r_sda_cnt <= '0;
      end else begin
         r_sync1  <= {sda_i, scl_i};
         r_sync2  <= r_sync1;
         r_filt_d <= r_filt;
         if (r_sync2[0] == r_filt[0]) begin
            r_scl_cnt <= '0;
         end else if (r_scl_cnt == CNT_MAX) begin
            r_filt[0] <= r_sync2[0];
            r_scl_cnt <= '0;
         end else begin
            r_scl_cnt <= r_scl_cnt + CNT_W'(1);
         end
         if (r_sync2[1] == r_filt[1]) begin
            r_sda_cnt <= '0;
         end else if (r_sda_cnt == CNT_MAX) begin
            r_filt[1] <= r_sync2[1];
            r_sda_cnt <= '0;
         end else begin
            r_sda_cnt <= r_sda_cnt + CNT_W'(1);
         end
      end
   end

   assign w_sda      = r_filt[1];
   assign w_scl_rise =  r_filt[0] & ~r_filt_d[0];
   assign w_scl_fall = ~r_filt[0] &  r_filt_d[0];
   assign w_start    = ~r_filt[1] &  r_filt_d[1] & r_filt[0];
   assign w_stop     =  r_filt[1] & ~r_filt_d[1] & r_filt[0];

   // Next-state decode; START/STOP override whatever the current state is doing
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_shift = r_shift;
      w_nxt_oe    = r_sda_oe;
      w_nxt_busy  = r_busy;
      w_nxt_ptr   = r_ptr;
      w_nxt_rw    = r_rw;
      w_nxt_ack   = r_ack_seen;
      w_bus_we    = 1'b0;
      w_rx_byte   = {r_shift[6:0], w_sda};
      if (w_stop) begin
         w_nxt_state = ST_IDLE;
         w_nxt_oe    = 1'b0;
         w_nxt_busy  = 1'b0;
      end else if (w_start) begin
         w_nxt_state = ST_ADDR;
         w_nxt_cnt   = 4'd0;
         w_nxt_oe    = 1'b0;
         w_nxt_ack   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_nxt_oe = 1'b0;
            end
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (w_scl_rise) begin
                  w_nxt_shift = w_rx_byte;
                  w_nxt_cnt   = r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     if (r_state == ST_ADDR) begin
                        if (w_rx_byte[7:1] == DEV_ADDR) begin
                           w_nxt_state = ST_ADDR_ACK;
                           w_nxt_busy  = 1'b1;
                           w_nxt_rw    = w_rx_byte[0];
                        end else begin
                           w_nxt_state = ST_IGNORE;
                        end
                     end else if (r_state == ST_PTR) begin
                        w_nxt_ptr   = w_rx_byte[PTR_W-1:0];
                        w_nxt_state = ST_PTR_ACK;
                     end else begin
                        w_bus_we    = 1'b1;
                        w_nxt_ptr   = r_ptr + PTR_W'(1);
                        w_nxt_state = ST_WDATA_ACK;
                     end
                  end
               end
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               // First falling edge pulls SDA low, the second one ends the slot
               if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     w_nxt_oe = 1'b1;
                  end else begin
                     w_nxt_oe  = 1'b0;
                     w_nxt_cnt = 4'd0;
                     if (r_state == ST_ADDR_ACK && r_rw) begin
                        w_nxt_state = ST_RDATA;
                        w_nxt_shift = r_regs[r_ptr];
                        w_nxt_oe    = ~r_regs[r_ptr][7];
                     end else if (r_state == ST_ADDR_ACK) begin
                        w_nxt_state = ST_PTR;
                     end else begin
                        w_nxt_state = ST_WDATA;
                     end
                  end
               end
            end
            ST_RDATA: begin
               // r_cnt counts bits already sampled by the master
               if (w_scl_rise && r_cnt != 4'd8) begin
                  w_nxt_cnt = r_cnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_nxt_oe    = 1'b0;
                     w_nxt_cnt   = 4'd0;
                     w_nxt_ack   = 1'b0;
                     w_nxt_state = ST_RACK;
                  end else begin
                     w_nxt_shift = {r_shift[6:0], r_shift[7]};
                     w_nxt_oe    = ~r_shift[6];
                  end
               end
            end
            ST_RACK: begin
               if (w_scl_rise) begin
                  w_nxt_ptr = r_ptr + PTR_W'(1);
                  if (!w_sda) begin
                     w_nxt_ack = 1'b1;
                  end else begin
                     w_nxt_state = ST_IGNORE;
                  end
               end else if (w_scl_fall && r_ack_seen) begin
                  w_nxt_state = ST_RDATA;
                  w_nxt_shift = r_regs[r_ptr];
                  w_nxt_oe    = ~r_regs[r_ptr][7];
                  w_nxt_cnt   = 4'd0;
                  w_nxt_ack   = 1'b0;
               end
            end
            ST_IGNORE: begin
               w_nxt_oe = 1'b0;
            end
            default: begin
               w_nxt_state = ST_IDLE;
               w_nxt_oe    = 1'b0;
            end
         endcase
      end
   end

   // Protocol state register; reset releases SDA without waiting for a clock
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_shift    <= 8'd0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_ptr      <= '0;
         r_rw       <= 1'b0;
         r_ack_seen <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_cnt      <= w_nxt_cnt;
         r_shift    <= w_nxt_shift;
         r_sda_oe   <= w_nxt_oe;
         r_busy     <= w_nxt_busy;
         r_ptr      <= w_nxt_ptr;
         r_rw       <= w_nxt_rw;
         r_ack_seen <= w_nxt_ack;
      end
   end

   // Register file; the bus write is applied last so it wins a same-index collision
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= 8'd0;
         end
      end else begin
         if (loc_we) begin
            r_regs[loc_addr] <= loc_wdata;
         end
         if (w_bus_we) begin
            r_regs[r_ptr] <= w_rx_byte;
         end
      end
   end

   // Bus write report, aligned with the register file update
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_stb      <= 1'b0;
         r_stb_addr <= '0;
         r_stb_data <= 8'd0;
      end else begin
         r_stb <= w_bus_we;
         if (w_bus_we) begin
            r_stb_addr <= r_ptr;
            r_stb_data <= w_rx_byte;
         end
      end
   end

   assign sda_oe      = r_sda_oe;
   assign busy        = r_busy;
   assign bus_wr_stb  = r_stb;
   assign bus_wr_addr = r_stb_addr;
   assign bus_wr_data = r_stb_data;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master drives the
// open-drain pair, bus writes are logged by a monitor and compared against an
// expected queue, and read data is compared against hand-computed bytes.
module tb_i2c_target_regfile;

   localparam int Q = 10;   // clocks per quarter SCL period

   logic       clk_clk = 1'b0;
   logic       reset_reset_n;
   logic       scl_m;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic       loc_we;
   logic [5:0] loc_addr;
   logic [7:0] loc_wdata;
   logic       bus_wr_stb;
   logic [5:0] bus_wr_addr;
   logic [7:0] bus_wr_data;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [13:0] exp_q[$];          // expected {addr, data} of bus writes
   logic [13:0] act_log [64];
   int          stb_cnt  = 0;
   int          stb_seen = 0;
   int          oe_cnt   = 0;
   int          busy_cnt = 0;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_regfile dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .scl_i         (scl_m),
      .sda_i         (sda_line),
      .sda_oe        (sda_oe),
      .loc_we        (loc_we),
      .loc_addr      (loc_addr),
      .loc_wdata     (loc_wdata),
      .bus_wr_stb    (bus_wr_stb),
      .bus_wr_addr   (bus_wr_addr),
      .bus_wr_data   (bus_wr_data),
      .busy          (busy)
   );

   // Clock
   always #5 clk_clk = ~clk_clk;

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, tests run %0d", tests_run);
      $fatal(1, "watchdog expired");
   end

   // Monitor: log bus write strobes and count cycles with SDA driven / busy
   always @(negedge clk_clk) begin
      if (sda_oe === 1'b1) oe_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (bus_wr_stb === 1'b1) begin
         act_log[stb_cnt % 64] = {bus_wr_addr, bus_wr_data};
         stb_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_strobes(input string tag);
      logic [13:0] e;
      check({tag, "_stb_count"}, stb_cnt - stb_seen, exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (stb_seen < stb_cnt) check({tag, "_stb_addr_data"}, act_log[stb_seen % 64], e);
         stb_seen++;
      end
      stb_seen = stb_cnt;
   endtask

   task automatic wait_q(input int n);
      repeat (n * Q) @(negedge clk_clk);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      sda_m = 1'b0; wait_q(1);
      scl_m = 1'b0; wait_q(1);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      sda_m = 1'b1; wait_q(2);
   endtask

   task automatic write_bit(input logic b, input logic glitch);
      sda_m = b; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      if (glitch) begin
         // one-clock low pulse on SCL, then one on SDA (only when SDA is high)
         scl_m = 1'b0; @(negedge clk_clk);
         scl_m = 1'b1; wait_q(1);
         if (b) begin
            sda_m = 1'b0; @(negedge clk_clk);
            sda_m = 1'b1;
         end
      end
      wait_q(1);
      scl_m = 1'b0; wait_q(1);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q(1);
      scl_m = 1'b1; wait_q(1);
      b = sda_line; wait_q(1);
      scl_m = 1'b0; wait_q(1);
   endtask

   // Send a byte and check the acknowledge bit against exp_ack
   task automatic send(input logic [7:0] b, input logic exp_ack, input string tag, input int glitch_bit);
      logic a;
      for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
      read_bit(a);
      check({tag, "_ack"}, a, exp_ack);
   endtask

   task automatic recv(output logic [7:0] v, input logic nack);
      logic bit_v;
      for (int i = 7; i >= 0; i--) begin
         read_bit(bit_v);
         v[i] = bit_v;
      end
      write_bit(nack, 1'b0);
   endtask

   task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
      loc_addr = a; loc_wdata = d; loc_we = 1'b1;
      @(negedge clk_clk);
      loc_we = 1'b0;
      @(negedge clk_clk);
   endtask

   initial begin
      logic [7:0] rd;
      int         oe_base;
      int         busy_base;

      // Reset
      reset_reset_n = 1'b0;
      scl_m = 1'b1; sda_m = 1'b1;
      loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
      repeat (4) @(negedge clk_clk);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_stb", bus_wr_stb, 0);
      check("rst_wr_addr", bus_wr_addr, 0);
      check("rst_wr_data", bus_wr_data, 0);
      reset_reset_n = 1'b1;
      wait_q(2);

      // Write pointer 0x05, data 0xA5, 0x3C
      i2c_start;
      send(8'h3A, 1'b0, "wr_addr", -1);
      check("wr_busy_high", busy, 1);
      send(8'h05, 1'b0, "wr_ptr", -1);
      send(8'hA5, 1'b0, "wr_d0", -1);
      exp_q.push_back({6'h05, 8'hA5});
      send(8'h3C, 1'b0, "wr_d1", -1);
      exp_q.push_back({6'h06, 8'h3C});
      i2c_stop;
      check("wr_busy_after_stop", busy, 0);
      check_strobes("wr");

      // Read back reg[5], reg[6]
      i2c_start;
      send(8'h3A, 1'b0, "rb_addr_w", -1);
      send(8'h05, 1'b0, "rb_ptr", -1);
      i2c_start;
      send(8'h3B, 1'b0, "rb_addr_r", -1);
      recv(rd, 1'b0);
      check("rb_reg05", rd, 8'hA5);
      recv(rd, 1'b1);
      check("rb_reg06", rd, 8'h3C);
      i2c_stop;

      // Local loads then a two-byte read at 0x32
      loc_write(6'h32, 8'h12);
      loc_write(6'h33, 8'h34);
      loc_write(6'h34, 8'h56);
      i2c_start;
      send(8'h3A, 1'b0, "loc_addr_w", -1);
      send(8'h32, 1'b0, "loc_ptr", -1);
      i2c_start;
      send(8'h3B, 1'b0, "loc_addr_r", -1);
      recv(rd, 1'b0);
      check("loc_reg32", rd, 8'h12);
      recv(rd, 1'b1);
      check("loc_reg33", rd, 8'h34);
      i2c_stop;
      // Pointer should now sit at 0x34
      i2c_start;
      send(8'h3B, 1'b0, "ptr_addr_r", -1);
      recv(rd, 1'b1);
      check("ptr_ends_0x34", rd, 8'h56);
      i2c_stop;
      check_strobes("loc");

      // Address mismatch: never drive SDA, no strobes, never busy
      oe_base   = oe_cnt;
      busy_base = busy_cnt;
      i2c_start;
      send(8'h40, 1'b1, "mis_addr", -1);
      send(8'hFF, 1'b1, "mis_d0", -1);
      send(8'h00, 1'b1, "mis_d1", -1);
      i2c_stop;
      check("mis_oe_cycles", oe_cnt - oe_base, 0);
      check("mis_busy_cycles", busy_cnt - busy_base, 0);
      check_strobes("mis");

      // Pointer wrap from 0x3F to 0x00
      i2c_start;
      send(8'h3A, 1'b0, "wrap_addr", -1);
      send(8'h3F, 1'b0, "wrap_ptr", -1);
      send(8'h11, 1'b0, "wrap_d0", -1);
      exp_q.push_back({6'h3F, 8'h11});
      send(8'h22, 1'b0, "wrap_d1", -1);
      exp_q.push_back({6'h00, 8'h22});
      i2c_stop;
      check_strobes("wrap");
      i2c_start;
      send(8'h3A, 1'b0, "wrap_rb_w", -1);
      send(8'h3F, 1'b0, "wrap_rb_ptr", -1);
      i2c_start;
      send(8'h3B, 1'b0, "wrap_rb_r", -1);
      recv(rd, 1'b0);
      check("wrap_reg3f", rd, 8'h11);
      recv(rd, 1'b1);
      check("wrap_reg00", rd, 8'h22);
      i2c_stop;

      // Glitches on SCL and SDA during a data bit are filtered out
      i2c_start;
      send(8'h3A, 1'b0, "gl_addr", -1);
      send(8'h10, 1'b0, "gl_ptr", -1);
      send(8'h77, 1'b0, "gl_data", 6);
      exp_q.push_back({6'h10, 8'h77});
      check("gl_busy_held", busy, 1);
      i2c_stop;
      check_strobes("gl");
      i2c_start;
      send(8'h3A, 1'b0, "gl_rb_w", -1);
      send(8'h10, 1'b0, "gl_rb_ptr", -1);
      i2c_start;
      send(8'h3B, 1'b0, "gl_rb_r", -1);
      recv(rd, 1'b1);
      check("gl_reg10", rd, 8'h77);
      i2c_stop;

      // Reset in the middle of a read of reg[0x32] = 0x12 (MSB 0 -> SDA pulled)
      i2c_start;
      send(8'h3A, 1'b0, "mr_addr_w", -1);
      send(8'h32, 1'b0, "mr_ptr", -1);
      i2c_start;
      send(8'h3B, 1'b0, "mr_addr_r", -1);
      check("mr_oe_before_reset", sda_oe, 1);
      reset_reset_n = 1'b0;
      #1;
      check("mr_oe_async_release", sda_oe, 0);
      check("mr_busy_cleared", busy, 0);
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      wait_q(1);
      i2c_stop;
      // Registers were cleared by reset
      i2c_start;
      send(8'h3A, 1'b0, "post_addr_w", -1);
      send(8'h05, 1'b0, "post_ptr", -1);
      i2c_start;
      send(8'h3B, 1'b0, "post_addr_r", -1);
      recv(rd, 1'b1);
      check("post_reg05_cleared", rd, 8'h00);
      i2c_stop;
      // A fresh write/read completes normally
      i2c_start;
      send(8'h3A, 1'b0, "post_wr_addr", -1);
      send(8'h20, 1'b0, "post_wr_ptr", -1);
      send(8'h9C, 1'b0, "post_wr_d", -1);
      exp_q.push_back({6'h20, 8'h9C});
      i2c_stop;
      check_strobes("post");
      i2c_start;
      send(8'h3A, 1'b0, "post_rb_w", -1);
      send(8'h20, 1'b0, "post_rb_ptr", -1);
      i2c_start;
      send(8'h3B, 1'b0, "post_rb_r", -1);
      recv(rd, 1'b1);
      check("post_reg20", rd, 8'h9C);
      i2c_stop;
      check("final_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
